// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache.
// Address/instruction ranges, FSM encodings and default geometry.
`ifndef ICACHE_PKG_SV
`define ICACHE_PKG_SV

`define addrRange 31:0
`define instRange 31:0

package icache_pkg;

  localparam int INDEX_BITS_DEF = 7;
  localparam int ADDR_BITS_DEF  = 18;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_e;

endpackage

`endif

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One combinational read port with tag compare, one registered write port.
module icache_array #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 9
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_idx,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic                  hit,
  output logic [31:0]           rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES];

  assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rd_data = data[rd_idx];

  // Valid bits are the only storage cleared by reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data follow the fill; contents are don't-care until valid.
  always_ff @(posedge clk_in) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between IF and the memory controller.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_EN.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              pcJump_in,
  input  logic              IF_in,
  input  logic [`addrRange] IFAddr_in,
  output logic              instE_out,
  output logic [`instRange] inst_out,
  output logic              MCE_out,
  output logic [`addrRange] MCAddr_out,
  input  logic              MC_busy_in,
  input  logic              MC_instE_in,
  input  logic [`instRange] MC_inst_in
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hitCnt_out,
  output logic [31:0]       missCnt_out
`endif
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  state_e      state;
  logic        cancel;
  logic        hit;
  logic [31:0] rd_data;
  logic        idle;
  logic        hit_go;
  logic        miss_go;
  logic        fill_go;
  logic        fill_we;

  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0]   wr_tag;

  // MC_busy_in only stretches the miss; the request is simply held.
  logic unused_ok;
  assign unused_ok = ^{MC_busy_in,
                       IFAddr_in[31:ADDR_BITS],
                       IFAddr_in[1:0]};

  assign rd_idx = IFAddr_in[INDEX_BITS+1:2];
  assign rd_tag = IFAddr_in[ADDR_BITS-1:INDEX_BITS+2];
  assign wr_idx = MCAddr_out[INDEX_BITS+1:2];
  assign wr_tag = MCAddr_out[ADDR_BITS-1:INDEX_BITS+2];

  assign idle    = (state == IDLE);
  assign hit_go  = idle && IF_in && hit && !pcJump_in;
  assign miss_go = idle && IF_in && !hit && !pcJump_in;
  assign fill_go = !idle && MC_instE_in;
  assign fill_we = fill_go && rdy_in && !rst_in;

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_idx  (rd_idx),
    .rd_tag  (rd_tag),
    .hit     (hit),
    .rd_data (rd_data),
    .we      (fill_we),
    .wr_idx  (wr_idx),
    .wr_tag  (wr_tag),
    .wr_data (MC_inst_in)
  );

  // Miss FSM: latch the miss address, track cancellation, finish on fill.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      cancel     <= 1'b0;
      MCAddr_out <= '0;
    end else if (rdy_in) begin
      unique case (state)
        IDLE: begin
          if (miss_go) begin
            MCAddr_out <= IFAddr_in;
            cancel     <= 1'b0;
            state      <= MISS;
          end
        end
        MISS: begin
          if (MC_instE_in) begin
            state <= IDLE;
          end else if (pcJump_in) begin
            cancel <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency hit path and same-cycle forwarding of fill data.
  always_comb begin
    instE_out = 1'b0;
    inst_out  = '0;
    MCE_out   = 1'b0;
    if (!rst_in && rdy_in) begin
      if (idle) begin
        if (hit_go) begin
          instE_out = 1'b1;
          inst_out  = rd_data;
        end
      end else begin
        MCE_out = 1'b1;
        if (MC_instE_in && !cancel && !pcJump_in) begin
          instE_out = 1'b1;
          inst_out  = MC_inst_in;
        end
      end
    end
  end

`ifdef ICACHE_PERF_EN
  // Delivered hits and IDLE-to-MISS transitions, wrapping at 2^32.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hitCnt_out  <= '0;
      missCnt_out <= '0;
    end else if (rdy_in) begin
      if (hit_go) hitCnt_out <= hitCnt_out + 32'd1;
      if (miss_go) missCnt_out <= missCnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed table, corner sequences,
// and randomized traffic against a line-level reference model.
`timescale 1ns/1ps
module tb_icache;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        pcJump_in;
  logic        IF_in;
  logic [31:0] IFAddr_in;
  logic        instE_out;
  logic [31:0] inst_out;
  logic        MCE_out;
  logic [31:0] MCAddr_out;
  logic        MC_busy_in;
  logic        MC_instE_in;
  logic [31:0] MC_inst_in;
`ifdef ICACHE_PERF_EN
  logic [31:0] hitCnt_out;
  logic [31:0] missCnt_out;
`endif

  icache dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .pcJump_in   (pcJump_in),
    .IF_in       (IF_in),
    .IFAddr_in   (IFAddr_in),
    .instE_out   (instE_out),
    .inst_out    (inst_out),
    .MCE_out     (MCE_out),
    .MCAddr_out  (MCAddr_out),
    .MC_busy_in  (MC_busy_in),
    .MC_instE_in (MC_instE_in),
    .MC_inst_in  (MC_inst_in)
`ifdef ICACHE_PERF_EN
    ,
    .hitCnt_out  (hitCnt_out),
    .missCnt_out (missCnt_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: per-line contents plus the single outstanding fill.
  bit          m_valid [128];
  int unsigned m_tag   [128];
  logic [31:0] m_data  [128];
  bit          m_miss;
  bit          m_cancel;
  logic [31:0] m_mca;
  logic [31:0] m_hc;
  logic [31:0] m_mc;

  logic        s_ie;
  logic [31:0] s_inst;
  logic        s_mce;
  logic [31:0] s_mca;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    m_miss   = 1'b0;
    m_cancel = 1'b0;
    m_mca    = '0;
    m_hc     = '0;
    m_mc     = '0;
  endtask

  // One clock: drive, check at negedge against model, advance model.
  task automatic step(input logic rst, input logic rdy, input logic jmp,
                      input logic ife, input logic [31:0] addr,
                      input logic busy, input logic mce,
                      input logic [31:0] md);
    int unsigned idx;
    int unsigned tg;
    int unsigned widx;
    bit          hit;
    logic        e_ie;
    logic [31:0] e_inst;
    logic        e_mce;
    rst_in      = rst;
    rdy_in      = rdy;
    pcJump_in   = jmp;
    IF_in       = ife;
    IFAddr_in   = addr;
    MC_busy_in  = busy;
    MC_instE_in = mce;
    MC_inst_in  = md;
    @(negedge clk);
    idx    = (addr / 4) % 128;
    tg     = (addr / 512) % 512;
    hit    = m_valid[idx] && (m_tag[idx] == tg);
    e_ie   = 1'b0;
    e_inst = '0;
    e_mce  = 1'b0;
    if (!rst && rdy) begin
      if (!m_miss) begin
        if (ife && hit && !jmp) begin
          e_ie   = 1'b1;
          e_inst = m_data[idx];
        end
      end else begin
        e_mce = 1'b1;
        if (mce && !m_cancel && !jmp) begin
          e_ie   = 1'b1;
          e_inst = md;
        end
      end
    end
    s_ie   = instE_out;
    s_inst = inst_out;
    s_mce  = MCE_out;
    s_mca  = MCAddr_out;
    chk("instE", {31'd0, s_ie}, {31'd0, e_ie});
    if (e_ie) chk("inst", s_inst, e_inst);
    chk("MCE", {31'd0, s_mce}, {31'd0, e_mce});
    chk("MCAddr", s_mca, m_mca);
`ifdef ICACHE_PERF_EN
    chk("hitCnt", hitCnt_out, m_hc);
    chk("missCnt", missCnt_out, m_mc);
`endif
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (rdy) begin
      if (!m_miss) begin
        if (ife && hit && !jmp) begin
          m_hc = m_hc + 1;
        end else if (ife && !jmp) begin
          m_miss   = 1'b1;
          m_cancel = 1'b0;
          m_mca    = addr;
          m_mc     = m_mc + 1;
        end
      end else if (mce) begin
        widx          = (m_mca / 4) % 128;
        m_valid[widx] = 1'b1;
        m_tag[widx]   = (m_mca / 512) % 512;
        m_data[widx]  = md;
        m_miss        = 1'b0;
      end else if (jmp) begin
        m_cancel = 1'b1;
      end
    end
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        jmp;
    logic        ife;
    logic [31:0] addr;
    logic        mce;
    logic [31:0] md;
    logic        e_ie;
    logic [31:0] e_inst;
    logic        e_mce;
    logic [31:0] e_mca;
  } vec_t;

  vec_t        tbl [19];
  logic [31:0] pool [6];

  initial begin
    int          dly;
    logic        r_rst;
    logic        r_rdy;
    logic        r_jmp;
    logic        r_ife;
    logic        r_busy;
    logic        r_mce;
    logic [31:0] r_addr;

    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,32'h000,1'b0,32'h00, 1'b0,32'h00,1'b0,32'h000};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b1,32'h100,1'b0,32'h00, 1'b0,32'h00,1'b0,32'h000};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b1,32'h100,1'b0,32'h00, 1'b0,32'h00,1'b1,32'h100};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b1,32'h100,1'b0,32'h00, 1'b0,32'h00,1'b1,32'h100};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b1,32'h100,1'b1,32'h13, 1'b1,32'h13,1'b1,32'h100};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b1,32'h100,1'b0,32'h00, 1'b1,32'h13,1'b0,32'h100};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b1,32'h300,1'b0,32'h00, 1'b0,32'h00,1'b0,32'h100};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b1,32'h300,1'b1,32'h33, 1'b1,32'h33,1'b1,32'h300};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,32'h300,1'b0,32'h00, 1'b1,32'h33,1'b0,32'h300};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b1,32'h100,1'b0,32'h00, 1'b0,32'h00,1'b0,32'h300};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b1,32'h100,1'b1,32'h13, 1'b1,32'h13,1'b1,32'h100};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b1,32'h200,1'b0,32'h00, 1'b0,32'h00,1'b0,32'h100};
    tbl[12] = '{1'b0,1'b1,1'b1,1'b1,32'h200,1'b0,32'h00, 1'b0,32'h00,1'b1,32'h200};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b0,32'h200,1'b1,32'h22, 1'b0,32'h00,1'b1,32'h200};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b1,32'h200,1'b0,32'h00, 1'b1,32'h22,1'b0,32'h200};
    tbl[15] = '{1'b0,1'b1,1'b1,1'b1,32'h200,1'b0,32'h00, 1'b0,32'h00,1'b0,32'h200};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b1,32'h400,1'b0,32'h00, 1'b0,32'h00,1'b0,32'h200};
    tbl[17] = '{1'b0,1'b1,1'b1,1'b1,32'h400,1'b1,32'h44, 1'b0,32'h00,1'b1,32'h400};
    tbl[18] = '{1'b0,1'b1,1'b0,1'b1,32'h400,1'b0,32'h00, 1'b1,32'h44,1'b0,32'h400};

    pool[0] = 32'h100;
    pool[1] = 32'h300;
    pool[2] = 32'h104;
    pool[3] = 32'h200;
    pool[4] = 32'h3FF00;
    pool[5] = 32'h0;

    rst_in      = 1'b1;
    rdy_in      = 1'b1;
    pcJump_in   = 1'b0;
    IF_in       = 1'b0;
    IFAddr_in   = '0;
    MC_busy_in  = 1'b0;
    MC_instE_in = 1'b0;
    MC_inst_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Directed table: cold miss, eviction, jump cases.
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].jmp, tbl[i].ife,
           tbl[i].addr, 1'b0, tbl[i].mce, tbl[i].md);
      chk($sformatf("tbl%0d.instE", i), {31'd0, s_ie},
          {31'd0, tbl[i].e_ie});
      if (tbl[i].e_ie)
        chk($sformatf("tbl%0d.inst", i), s_inst, tbl[i].e_inst);
      chk($sformatf("tbl%0d.MCE", i), {31'd0, s_mce},
          {31'd0, tbl[i].e_mce});
      chk($sformatf("tbl%0d.MCAddr", i), s_mca, tbl[i].e_mca);
    end

    // Controller busy for 5 cycles: request held stable.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    chk("busy.enter", {31'd0, s_mce}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0);
      chk("busy.MCE", {31'd0, s_mce}, 32'd1);
      chk("busy.MCAddr", s_mca, 32'h500);
      chk("busy.instE", {31'd0, s_ie}, 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 1'b1, 32'h55);
    chk("busy.deliver", {31'd0, s_ie}, 32'd1);
    chk("busy.inst", s_inst, 32'h55);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    chk("busy.rehit", s_inst, 32'h55);

    // rdy_in low for 3 cycles in the middle of a miss.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
      chk("stall.MCE", {31'd0, s_mce}, 32'd0);
      chk("stall.instE", {31'd0, s_ie}, 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
    chk("stall.resume", {31'd0, s_mce}, 32'd1);
    chk("stall.MCAddr", s_mca, 32'h600);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 1'b1, 32'h66);
    chk("stall.deliver", s_inst, 32'h66);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    chk("stall.oldline", {31'd0, s_ie}, 32'd1);
    chk("stall.olddata", s_inst, 32'h55);

    // Reset mid-miss, then a stray data pulse while idle.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h700, 1'b0, 1'b1, 32'h77);
    chk("stray.instE", {31'd0, s_ie}, 32'd0);
    chk("stray.MCE", {31'd0, s_mce}, 32'd0);
    chk("stray.MCAddr", s_mca, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0);
    chk("rst.remiss", {31'd0, s_ie}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0);
    chk("rst.MCE", {31'd0, s_mce}, 32'd1);
    chk("rst.MCAddr", s_mca, 32'h700);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 1'b1, 32'h70);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h000, 1'b0, 1'b0, 32'h0);
    chk("stray.nowrite", {31'd0, s_ie}, 32'd0);

    // Randomized traffic with a loosely modelled controller.
    dly = 2;
    for (int n = 0; n < 4000; n++) begin
      r_rst  = ($urandom % 100) == 0;
      r_rdy  = ($urandom % 10) != 0;
      r_jmp  = ($urandom % 12) == 0;
      r_ife  = ($urandom % 5) != 0;
      r_busy = ($urandom % 2) == 0;
      if (($urandom % 4) == 0)
        r_addr = $urandom & 32'h3FFFC;
      else
        r_addr = pool[$urandom % 6];
      if (m_miss) begin
        if (dly == 0) begin
          r_mce = 1'b1;
          dly   = $urandom % 4;
        end else begin
          r_mce = 1'b0;
          dly--;
        end
      end else begin
        r_mce = ($urandom % 30) == 0;
      end
      step(r_rst, r_rdy, r_jmp, r_ife, r_addr, r_busy, r_mce, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
